// File: rtl/vend_controller.sv
// Vending sequencer: collects nickel/dime credit, requests a vend, then returns change or a refund one nickel at a time.
// Latency: every output is a register. VEND follows an accepting coin edge by one evaluation cycle.
// Backpressure: soda_req and nickel_out_req are levels held until vend_ack / coin_ack. Coins that cannot be taken are refused with coin_reject.
module vend_controller #(
    parameter int PRICE      = 25,
    parameter int MAX_CREDIT = 95,
    parameter int TIMEOUT    = 500000000,
    parameter int CW         = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          nickel_in,
    input  logic          dime_in,
    input  logic          cancel,
    input  logic          vend_ack,
    input  logic          coin_ack,
    output logic [CW-1:0] credit,
    output logic          soda_req,
    output logic          nickel_out_req,
    output logic          coin_reject,
    output logic          busy,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        VEND    = 3'd2,
        CHANGE  = 3'd3,
        REFUND  = 3'd4
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_CREDIT);
    localparam logic [CW-1:0] NICKEL_C = CW'(5);
    localparam logic [CW-1:0] DIME_C   = CW'(10);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   credit_n;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_n;
    logic            reject_n;
    logic            coin_evt;
    logic [CW-1:0]   coin_val;
    logic [CW-1:0]   coin_sum;

    // Coin event value; a nickel and a dime together are a single 15-cent event.
    always_comb begin
        coin_evt = nickel_in | dime_in;
        coin_val = ({CW{nickel_in}} & NICKEL_C) + ({CW{dime_in}} & DIME_C);
        coin_sum = credit + coin_val;
    end

    // Next-state, next-credit and timer logic.
    always_comb begin
        state_n  = state;
        credit_n = credit;
        timer_n  = timer;
        reject_n = 1'b0;

        case (state)
            IDLE: begin
                timer_n = '0;
                if (coin_evt) begin
                    if (coin_val <= MAX_C) begin
                        credit_n = coin_val;
                        state_n  = COLLECT;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end

            COLLECT: begin
                if (cancel) begin
                    // Cancel wins; a coin in the same cycle goes straight back.
                    state_n  = REFUND;
                    reject_n = coin_evt;
                end else begin
                    if (coin_evt) begin
                        if (coin_sum <= MAX_C) begin
                            credit_n = coin_sum;
                            timer_n  = '0;
                        end else begin
                            reject_n = 1'b1;
                        end
                    end
                    // Price check looks at the registered credit, hence the one-cycle evaluation gap.
                    if (credit >= PRICE_C) begin
                        state_n = VEND;
                    end else if (!coin_evt) begin
                        if (timer == TMO_LAST) begin
                            state_n = REFUND;
                        end else begin
                            timer_n = timer + TW'(1);
                        end
                    end
                end
            end

            VEND: begin
                reject_n = coin_evt;
                if (vend_ack && (credit >= PRICE_C)) begin
                    credit_n = credit - PRICE_C;
                    state_n  = (credit > PRICE_C) ? CHANGE : IDLE;
                end
            end

            CHANGE, REFUND: begin
                reject_n = coin_evt;
                // Acks only count while a nickel is actually being requested.
                if (coin_ack && nickel_out_req && (credit >= NICKEL_C)) begin
                    credit_n = credit - NICKEL_C;
                    if (credit == NICKEL_C) begin
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n  = IDLE;
                credit_n = '0;
                timer_n  = '0;
            end
        endcase
    end

    // State, credit, timer and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            credit         <= '0;
            timer          <= '0;
            soda_req       <= 1'b0;
            nickel_out_req <= 1'b0;
            coin_reject    <= 1'b0;
            busy           <= 1'b0;
            state_dbg      <= 3'd0;
        end else begin
            state          <= state_n;
            credit         <= credit_n;
            timer          <= timer_n;
            soda_req       <= (state_n == VEND);
            nickel_out_req <= ((state_n == CHANGE) || (state_n == REFUND)) && (credit_n != '0);
            coin_reject    <= reject_n;
            busy           <= (state_n == VEND) || (state_n == CHANGE) || (state_n == REFUND);
            state_dbg      <= state_n;
        end
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sequencing FSM for the soda vending datapath: accepts debounced coin pulses, accumulates credit, requests a vend, then pays change or refunds one nickel at a time over a req/ack handshake.
- Sits between the coin/button debouncers and the dispenser outputs.
- The credit output feeds the existing BintoBCD / multiseg_driver display chain directly.
- Replaces the combinational switch-sum scheme with a clocked, event-driven controller.

Parameters:
- PRICE, 25: vend price in cents; must be a nonzero multiple of 5 and no greater than MAX_CREDIT.
- MAX_CREDIT, 95: credit ceiling in cents; must be a multiple of 5.
- TIMEOUT, 500000000: cycles with no coin in COLLECT before auto-refund (5 s at 100 MHz).
- CW, 12: credit width; matches the BintoBCD bin_in width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- nickel_in  input  1  one-cycle pulse, 5-cent coin inserted
- dime_in  input  1  one-cycle pulse, 10-cent coin inserted
- cancel  input  1  one-cycle pulse, refund request
- vend_ack  input  1  dispenser has released the soda
- coin_ack  input  1  change mechanism has ejected one nickel
- credit  output  CW  current credit in cents, binary
- soda_req  output  1  vend request, level
- nickel_out_req  output  1  eject-one-nickel request, level
- coin_reject  output  1  one-cycle pulse; an inserted coin was refused (mechanism returns it)
- busy  output  1  high in VEND, CHANGE and REFUND
- state_dbg  output  3  encoded state, for LEDs and debug

Behaviour:
- Reset (sampled on clk rising edge while rst=1):
  - state=IDLE; credit=0; timer=0.
  - soda_req, nickel_out_req, coin_reject and busy are all 0.
  - Reset mid-VEND or mid-CHANGE abandons the transaction; no outputs persist afterwards.
- State encoding: IDLE=0, COLLECT=1, VEND=2, CHANGE=3, REFUND=4.
- Coin value each cycle: v = 5*nickel_in + 10*dime_in. A simultaneous nickel and dime are one event with v=15.
- IDLE:
  - v>0: credit<=v, go to COLLECT.
  - cancel alone: ignored.
- COLLECT:
  - Priority order: cancel, then coin, then timeout.
  - cancel: go to REFUND. Any coin in the same cycle is rejected (coin_reject=1) and not credited.
  - v>0 and credit+v<=MAX_CREDIT: credit<=credit+v; timer<=0.
  - v>0 and credit+v>MAX_CREDIT: coin_reject=1 for one cycle; credit unchanged. The combined 15-cent event is rejected whole.
  - No coin: timer increments. At timer==TIMEOUT-1, go to REFUND.
  - Credit check uses the registered credit: when credit>=PRICE, go to VEND on the next edge. An accepting edge is therefore followed by one evaluation cycle, so the VEND transition happens 2 cycles after the coin pulse.
- VEND:
  - soda_req=1, held until the cycle vend_ack=1 is sampled.
  - On ack: credit<=credit-PRICE; soda_req drops the next cycle.
  - Next state: CHANGE if credit-PRICE>0, else IDLE.
  - cancel is ignored.
- CHANGE and REFUND (identical datapath; the distinct state exists only for state_dbg):
  - nickel_out_req=1 while credit>0.
  - Each cycle with coin_ack=1: credit<=credit-5.
  - When the decrement reaches 0: go to IDLE; nickel_out_req=0 from that cycle.
  - coin_ack while nickel_out_req=0 is ignored.
  - Entering REFUND with credit==0 is impossible, because COLLECT always holds credit>=5.
- Coins arriving in VEND, CHANGE or REFUND: coin_reject pulse; no credit change.
- timer clears on every state entry to COLLECT and on every accepted coin.
- Arithmetic:
  - All sums are unsigned CW-bit.
  - credit never exceeds MAX_CREDIT and never underflows.
  - Subtraction occurs only after the guarding comparison.
- busy is 1 in VEND, CHANGE and REFUND, else 0. All outputs are registered.

Test Plan:
- Dime, dime, nickel (5 cycles apart), then vend_ack 3 cycles after soda_req rises:
  - credit goes 10, 20, 25.
  - soda_req rises 2 cycles after the nickel.
  - credit=0 after ack; back in IDLE; nickel_out_req never asserted.
- Three dimes, then ack vend; ack each nickel request after 2 cycles:
  - credit=30; VEND; credit=5 after vend_ack.
  - One nickel_out_req/coin_ack exchange, then IDLE with credit=0.
- Nickel and dime in the same cycle, then dime:
  - credit=15, then 25; VEND entered.
- Nickel, then cancel and dime in the same cycle:
  - coin_reject pulse; REFUND with credit=5.
  - One nickel dispensed; IDLE.
- MAX_CREDIT=20, PRICE=25 (with the constraint check relaxed for the bench): two dimes, then a nickel:
  - The nickel is rejected and credit stays 20.
  - After TIMEOUT idle cycles, REFUND dispenses 4 nickels and returns to IDLE.
- Assert rst during CHANGE with credit=15:
  - Next cycle: state=IDLE, credit=0, all outputs 0.
